// File: rtl/phy_reg_maint_ctrl_pkg.sv
// Shared types for the physical register file maintenance controller:
// the sequencer states and the default register-file geometry.
package phy_reg_maint_ctrl_pkg;

  localparam int PSCALAR_NUM       = 64;
  localparam int PREG_DATA_WIDTH   = 33;
  localparam int PSCALAR_IDX_WIDTH = $clog2(PSCALAR_NUM);

  typedef logic [PREG_DATA_WIDTH-1:0]   preg_data_path_t;
  typedef logic [PSCALAR_IDX_WIDTH-1:0] pscalar_reg_num_path_t;

  typedef enum logic [1:0] {
    MS_INIT,
    MS_IDLE,
    MS_DUMP,
    MS_DRAIN
  } maint_state_e;

endpackage

// File: rtl/preg_dump_skid_buf.sv
// Two-entry FIFO holding dumped register entries, tagged with their index,
// with a synchronous flush that discards everything buffered.
module preg_dump_skid_buf #(
  parameter int DATA_WIDTH = 33,
  parameter int IDX_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic [IDX_WIDTH-1:0]  i_idx,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [IDX_WIDTH-1:0]  o_idx,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_data [2];
  logic [IDX_WIDTH-1:0]  r_idx  [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_pop;

  assign w_pop   = o_valid && i_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_idx   = r_idx[r_rd_ptr];
  assign o_data  = r_data[r_rd_ptr];
  assign o_count = r_count;

  // NOTE: storage has no reset; r_count gates every read of it.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_data[r_wr_ptr] <= i_data;
      r_idx[r_wr_ptr]  <= i_idx;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/phy_reg_maint_ctrl.sv
// Zero-initialises every physical register through all write ports after
// reset/initStart, then streams full dumps out through a borrowed read port.
module phy_reg_maint_ctrl
  import phy_reg_maint_ctrl_pkg::*;
#(
  parameter int ENTRY_NUM  = PSCALAR_NUM,
  parameter int WRITE_NUM  = 4,
  parameter int DATA_WIDTH = PREG_DATA_WIDTH,
  parameter int IDX_WIDTH  = $clog2(ENTRY_NUM)
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic                            initStart,
  output logic                            initBusy,
  output logic                            initDone,
  output logic [WRITE_NUM-1:0]            initWE,
  output logic [WRITE_NUM*IDX_WIDTH-1:0]  initWA,
  output logic [WRITE_NUM*DATA_WIDTH-1:0] initWV,
  input  logic                            dumpReq,
  output logic                            dumpBusy,
  input  logic                            rdGrant,
  output logic                            rdReq,
  output logic [IDX_WIDTH-1:0]            rdAddr,
  input  logic [DATA_WIDTH-1:0]           rdData,
  output logic                            outValid,
  input  logic                            outReady,
  output logic [IDX_WIDTH-1:0]            outIndex,
  output logic [DATA_WIDTH-1:0]           outData
);

  localparam int CNT_W = IDX_WIDTH + 1;
  localparam int SUM_W = IDX_WIDTH + 2;
  localparam logic [DATA_WIDTH-1:0] INIT_VALUE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  maint_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_rst_index;
  logic                 r_init_done;
  logic [IDX_WIDTH-1:0] r_rd_idx;
  logic                 r_inflight;
  logic [1:0]           w_buf_count;
  logic [1:0]           w_occupancy;
  logic                 w_init_last;
  logic                 w_rd_fire;
  logic                 w_drain_done;
  logic                 w_dump_start;

  // Sums are one bit wider than the index so the last partial beat masks
  // its spare ports instead of wrapping onto entry 0.
  assign w_init_last  = ({1'b0, r_rst_index} + SUM_W'(WRITE_NUM)) >= SUM_W'(ENTRY_NUM);
  assign w_occupancy  = w_buf_count + {1'b0, r_inflight};
  assign w_rd_fire    = rdReq && rdGrant;
  assign w_dump_start = (r_state == MS_IDLE) && dumpReq && r_init_done && !initStart;
  assign w_drain_done = (r_state == MS_DRAIN) && !r_inflight &&
                        ((w_buf_count == 2'd0) || ((w_buf_count == 2'd1) && outReady));
  assign initDone     = r_init_done;
  assign rdAddr       = r_rd_idx;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= MS_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (initStart) begin
      w_state_nxt = MS_INIT;
    end else begin
      unique case (r_state)
        MS_INIT:  if (w_init_last) w_state_nxt = MS_IDLE;
        MS_IDLE:  if (w_dump_start) w_state_nxt = MS_DUMP;
        MS_DUMP:  if (w_rd_fire && (r_rd_idx == IDX_WIDTH'(ENTRY_NUM - 1))) w_state_nxt = MS_DRAIN;
        MS_DRAIN: if (w_drain_done) w_state_nxt = MS_IDLE;
        default:  w_state_nxt = MS_INIT;
      endcase
    end
  end

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    initBusy = (r_state == MS_INIT);
    dumpBusy = ((r_state == MS_DUMP) || (r_state == MS_DRAIN)) && !w_drain_done;
    rdReq    = (r_state == MS_DUMP) && !initStart && (w_occupancy < 2'd2);
    initWE   = '0;
    initWA   = '0;
    initWV   = '0;
    for (int i = 0; i < WRITE_NUM; i++) begin
      initWE[i] = initBusy && ((r_rst_index + CNT_W'(i)) < CNT_W'(ENTRY_NUM));
      initWA[i*IDX_WIDTH +: IDX_WIDTH]   = IDX_WIDTH'(r_rst_index + CNT_W'(i));
      initWV[i*DATA_WIDTH +: DATA_WIDTH] = INIT_VALUE;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_rst_index <= '0;
      r_init_done <= 1'b0;
      r_rd_idx    <= '0;
      r_inflight  <= 1'b0;
    end else if (initStart) begin
      r_rst_index <= '0;
      r_init_done <= 1'b0;
      r_inflight  <= 1'b0;
    end else begin
      if (r_state == MS_INIT) begin
        r_rst_index <= r_rst_index + CNT_W'(WRITE_NUM);
        if (w_init_last) r_init_done <= 1'b1;
      end
      r_inflight <= w_rd_fire;
      if (w_dump_start)   r_rd_idx <= '0;
      else if (w_rd_fire) r_rd_idx <= r_rd_idx + IDX_WIDTH'(1);
    end
  end

  // Read data lands one cycle after acceptance; its index is rdAddr minus one
  // because rdAddr advanced on the accepting edge.
  preg_dump_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rstN    (rstN),
    .i_flush (initStart),
    .i_push  (r_inflight),
    .i_idx   (r_rd_idx - IDX_WIDTH'(1)),
    .i_data  (rdData),
    .o_valid (outValid),
    .i_ready (outReady),
    .o_idx   (outIndex),
    .o_data  (outData),
    .o_count (w_buf_count)
  );

endmodule

// File: tb/tb_phy_reg_maint_ctrl.sv
// Scoreboard bench: dump requests push the expected entries into a queue and
// a monitor pops and compares every accepted output beat.
`timescale 1ns/1ps
module tb_phy_reg_maint_ctrl;

  localparam int E   = 64;
  localparam int W   = 4;
  localparam int DW  = 33;
  localparam int IW  = 6;
  localparam int SE  = 10;
  localparam int SIW = 4;
  localparam logic [DW-1:0] ZERO_VALID = {1'b1, {(DW-1){1'b0}}};

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic initStart = 1'b0, dumpReq = 1'b0, rdGrant = 1'b0, outReady = 1'b0;
  logic [DW-1:0] rdData = '0;
  logic initBusy, initDone, dumpBusy, rdReq, outValid;
  logic [W-1:0] initWE;
  logic [W*IW-1:0] initWA;
  logic [W*DW-1:0] initWV;
  logic [IW-1:0] rdAddr, outIndex;
  logic [DW-1:0] outData;

  logic s_initStart = 1'b0, s_dumpReq = 1'b0, s_rdGrant = 1'b0, s_outReady = 1'b1;
  logic [DW-1:0] s_rdData = '0;
  logic s_initBusy, s_initDone, s_dumpBusy, s_rdReq, s_outValid;
  logic [W-1:0] s_initWE;
  logic [W*SIW-1:0] s_initWA;
  logic [W*DW-1:0] s_initWV;
  logic [SIW-1:0] s_rdAddr, s_outIndex;
  logic [DW-1:0] s_outData;

  always #5 clk = ~clk;

  phy_reg_maint_ctrl #(.ENTRY_NUM(E), .WRITE_NUM(W), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rstN(rstN), .initStart(initStart), .initBusy(initBusy), .initDone(initDone),
    .initWE(initWE), .initWA(initWA), .initWV(initWV), .dumpReq(dumpReq), .dumpBusy(dumpBusy),
    .rdGrant(rdGrant), .rdReq(rdReq), .rdAddr(rdAddr), .rdData(rdData), .outValid(outValid),
    .outReady(outReady), .outIndex(outIndex), .outData(outData)
  );

  phy_reg_maint_ctrl #(.ENTRY_NUM(SE), .WRITE_NUM(W), .DATA_WIDTH(DW), .IDX_WIDTH(SIW)) dut_small (
    .clk(clk), .rstN(rstN), .initStart(s_initStart), .initBusy(s_initBusy), .initDone(s_initDone),
    .initWE(s_initWE), .initWA(s_initWA), .initWV(s_initWV), .dumpReq(s_dumpReq), .dumpBusy(s_dumpBusy),
    .rdGrant(s_rdGrant), .rdReq(s_rdReq), .rdAddr(s_rdAddr), .rdData(s_rdData), .outValid(s_outValid),
    .outReady(s_outReady), .outIndex(s_outIndex), .outData(s_outData)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  exp_t exp_q[$];
  logic [DW-1:0] mem [E];
  int wr_cnt [E];
  int s_wr_cnt [SE];
  logic rd_fire_q = 1'b0;
  logic [IW-1:0] rd_addr_q = '0;
  int acc_reads = 0, pops = 0, occ = 0, max_occ = 0, beats_seen = 0;
  logic prev_stall = 1'b0, prev_flush = 1'b0;
  logic [IW+DW-1:0] prev_beat = '0;

  // Register-file model, read-port model and output monitor, all sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rstN) begin
      prev_stall = 1'b0;
      acc_reads  = 0;
      pops       = 0;
      rd_fire_q  = 1'b0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (initWE[i]) begin
          mem[initWA[i*IW +: IW]] = initWV[i*DW +: DW];
          wr_cnt[initWA[i*IW +: IW]]++;
        end
        if (s_initWE[i]) s_wr_cnt[s_initWA[i*SIW +: SIW]]++;
      end
      if (s_outValid) check("small_no_beats", {s_outIndex, s_outData}, '1);
      if (prev_stall && !prev_flush)
        check("stall_hold", {outValid, outIndex, outData}, {1'b1, prev_beat});
      occ = acc_reads - pops;
      if (occ > max_occ) max_occ = occ;
      if (outValid && outReady) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat_index", outIndex, e.idx);
          check("beat_data", outData, e.data);
        end
        beats_seen++;
        pops++;
      end
      rd_fire_q = rdReq && rdGrant;
      rd_addr_q = rdAddr;
      if (rd_fire_q) acc_reads++;
      prev_stall = outValid && !outReady;
      prev_beat  = {outIndex, outData};
      prev_flush = initStart;
      if (initStart) begin
        acc_reads = 0;
        pops      = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rdData = rd_fire_q ? mem[rd_addr_q] : {DW{1'b1}};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_dump();
    exp_t e;
    step();
    dumpReq = 1'b1;
    for (int i = 0; i < E; i++) begin
      e.idx  = IW'(i);
      e.data = mem[i];
      exp_q.push_back(e);
    end
    step();
    dumpReq = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, last_acc, first_low, bad, beats_at_abort;
    logic busy_seen, done;
    logic [W*IW-1:0] exp_wa;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_init_busy", initBusy, 1);
    check("rst_init_done", initDone, 0);
    check("rst_dump_busy", dumpBusy, 0);
    check("rst_rd_req", rdReq, 0);
    check("rst_out_valid", outValid, 0);
    step();
    rstN = 1'b1;

    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      for (int j = 0; j < W; j++) exp_wa[j*IW +: IW] = IW'(4 * k + j);
      check("sweep_we", initWE, 4'hF);
      check("sweep_wa", initWA, exp_wa);
      check("sweep_done_low", initDone, 0);
      if (k < 3) begin
        check("small_we", s_initWE, (k == 2) ? 4'b0011 : 4'b1111);
        check("small_wa0", s_initWA[SIW-1:0], 4 * k);
      end
      if (k == 2) check("small_wa1", s_initWA[2*SIW-1:SIW], 9);
      if (k == 3) begin
        check("small_done", s_initDone, 1);
        check("small_we_idle", s_initWE, 0);
      end
    end
    check("sweep_wv0", initWV[DW-1:0], ZERO_VALID);
    @(negedge clk);
    check("sweep_done", initDone, 1);
    check("sweep_busy_low", initBusy, 0);
    check("sweep_we_idle", initWE, 0);
    bad = 0;
    for (int i = 0; i < E; i++) if (wr_cnt[i] != 1 || mem[i] !== ZERO_VALID) bad++;
    check("sweep_coverage_bad", bad, 0);
    bad = 0;
    for (int i = 0; i < SE; i++) if (s_wr_cnt[i] != 1) bad++;
    check("small_coverage_bad", bad, 0);
    check("small_quiet", {s_dumpBusy, s_rdReq, s_initBusy, s_rdAddr, s_initWV[DW-1:0]}, {3'b000, 4'd0, ZERO_VALID});

    for (int i = 0; i < E; i++) mem[i] = {1'(i % 2 == 0), 32'h5A00_0000 + 32'(i * 257)};

    // Full-rate dump.
    rdGrant = 1'b1;
    outReady = 1'b1;
    beats_seen = 0;
    issue_dump();
    last_acc = -1;
    first_low = -1;
    for (cyc = 0; cyc < 400 && first_low < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        check("dump1_busy_rise", dumpBusy, 1);
        check("dump1_first_req", {rdReq, rdAddr}, {1'b1, 6'd0});
      end
      if (rdReq && rdGrant && rdAddr == IW'(E - 1)) last_acc = cyc;
      if (last_acc >= 0 && !dumpBusy) first_low = cyc;
    end
    @(negedge clk);
    check("dump1_beats", beats_seen, E);
    check("dump1_busy_drop_latency", first_low - last_acc, 2);

    // Randomised grant and backpressure.
    beats_seen = 0;
    max_occ = 0;
    issue_dump();
    done = 1'b0;
    for (cyc = 0; cyc < 4000 && !done; cyc++) begin
      step();
      rdGrant  = ($urandom_range(0, 99) < 30);
      outReady = ($urandom_range(0, 99) < 50);
      @(negedge clk);
      if (beats_seen == E && !dumpBusy) done = 1'b1;
    end
    rdGrant = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    check("dump2_done", done, 1);
    check("dump2_beats", beats_seen, E);
    check("dump2_max_outstanding", max_occ <= 2, 1);

    // Abort at beat 20; a dumpReq during the re-sweep must be dropped.
    beats_seen = 0;
    issue_dump();
    cyc = 0;
    while (beats_seen < 20 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_beat20", beats_seen >= 20, 1);
    step();
    initStart = 1'b1;
    step();
    initStart = 1'b0;
    exp_q.delete();
    beats_at_abort = beats_seen;
    @(negedge clk);
    check("abort_out_valid", outValid, 0);
    check("abort_dump_busy", dumpBusy, 0);
    check("abort_init_busy", initBusy, 1);
    check("abort_we", initWE, 4'hF);
    check("abort_wa0", initWA[IW-1:0], 0);
    check("abort_done_low", initDone, 0);
    busy_seen = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      step();
      dumpReq = (k == 5);
      @(negedge clk);
      busy_seen |= dumpBusy | rdReq;
      if (k == 16) check("reinit_done_low", initDone, 0);
    end
    step();
    dumpReq = 1'b0;
    @(negedge clk);
    check("reinit_done", initDone, 1);
    repeat (5) begin
      @(negedge clk);
      busy_seen |= dumpBusy | rdReq;
    end
    check("dump_in_init_dropped", busy_seen, 0);
    check("no_beats_after_abort", beats_seen, beats_at_abort);

    // initStart and dumpReq together: initStart wins.
    step();
    initStart = 1'b1;
    dumpReq = 1'b1;
    step();
    initStart = 1'b0;
    dumpReq = 1'b0;
    @(negedge clk);
    check("simul_init_busy", initBusy, 1);
    check("simul_dump_busy", dumpBusy, 0);
    check("simul_done_low", initDone, 0);
    busy_seen = 1'b0;
    cyc = 0;
    while (!initDone && cyc < 40) begin
      @(negedge clk);
      busy_seen |= dumpBusy | rdReq;
      cyc++;
    end
    check("simul_reinit_done", initDone, 1);
    repeat (3) begin
      @(negedge clk);
      busy_seen |= dumpBusy | rdReq;
    end
    check("simul_dump_dropped", busy_seen, 0);

    // Recovery: a normal dump after the aborts.
    for (int i = 0; i < E; i++) mem[i] = {1'b1, 32'hC0DE_0000 ^ 32'(i * 4099)};
    beats_seen = 0;
    issue_dump();
    cyc = 0;
    while ((beats_seen < E || dumpBusy) && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check("dump3_beats", beats_seen, E);
    check("dump3_busy_low", dumpBusy, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/phy_reg_maint_ctrl.md
Name: phy_reg_maint_ctrl

Overview:
- Maintenance controller for the physical register file.
- Sequences the zero-initialisation of all PSCALAR_NUM entries by borrowing every write port. Entry 0 must read 0x0 because it backs the zero register, so the sweep is mandatory in synthesis too.
- After initialisation, serves debug/checkpoint dump requests by borrowing one read port and streaming the contents out through a valid/ready interface.
- Sits beside the register file. Its outputs override the pipeline write ports while initBusy=1.

Parameters:
- ENTRY_NUM, 64, number of physical registers (PSCALAR_NUM).
- WRITE_NUM, 4, write ports cleared per cycle; ENTRY_NUM need not be a multiple.
- DATA_WIDTH, 33, bits of PRegDataPath (data + valid).
- IDX_WIDTH, $clog2(ENTRY_NUM), entry index width.

Ports:
- clk  in  1  clock.
- rstN  in  1  asynchronous active-low reset.
- initStart  in  1  synchronous pulse; (re)starts the initialisation sweep.
- initBusy  out  1  write ports owned by this block.
- initDone  out  1  sweep complete since the last reset/initStart.
- initWE  out  WRITE_NUM  per-port write enable.
- initWA  out  WRITE_NUM*IDX_WIDTH  write addresses; port i in bits [i*IDX_WIDTH +: IDX_WIDTH].
- initWV  out  WRITE_NUM*DATA_WIDTH  write value; data=0, valid=1 (MSB).
- dumpReq  in  1  pulse; request a full dump.
- dumpBusy  out  1  dump in progress.
- rdGrant  in  1  borrowed read port free this cycle.
- rdReq  out  1  read issued this cycle.
- rdAddr  out  IDX_WIDTH  read address.
- rdData  in  DATA_WIDTH  read data, valid exactly 1 cycle after rdReq&&rdGrant.
- outValid  out  1  stream valid.
- outReady  in  1  stream ready.
- outIndex  out  IDX_WIDTH  entry index of outData.
- outData  out  DATA_WIDTH  entry contents.

Behaviour:
- Reset (rstN=0, async): state=INIT, rstIndex=0, initDone=0, dumpBusy=0, rdReq=0, outValid=0, skid buffer empty. initBusy=1 during reset, so the sweep starts on the first clock after release.
- States: INIT, IDLE, DUMP, DRAIN.
- INIT:
  - initBusy=1; initWE[i]=(rstIndex+i < ENTRY_NUM); initWA[i]=rstIndex+i; rstIndex += WRITE_NUM each cycle.
  - Compute rstIndex+i at IDX_WIDTH+1 bits, so the last partial beat masks out-of-range ports instead of wrapping.
  - When rstIndex+WRITE_NUM >= ENTRY_NUM: go to IDLE and set initDone=1 the next cycle.
  - Latency: ceil(ENTRY_NUM/WRITE_NUM) cycles.
- IDLE: initWE=0. dumpReq && initDone -> DUMP with rdIdx=0. dumpReq in INIT is dropped (not queued).
- DUMP:
  - rdReq=1 only when credit available; credit = skid-buffer free slots minus reads in flight (capacity 2).
  - A read is accepted when rdReq && rdGrant; rdIdx then increments.
  - When the last index (ENTRY_NUM-1) is accepted -> DRAIN.
- DRAIN: wait for the in-flight read and the buffer to empty -> IDLE; dumpBusy drops the same cycle.
- Stream output:
  - Returned data enters the 2-entry skid buffer (FIFO order), tagged with its index.
  - outValid/outData/outIndex must stay stable while outValid && !outReady.
  - Exactly ENTRY_NUM beats per dump, indices 0..ENTRY_NUM-1, no duplicates.
- initStart priority: initStart in any state (including DUMP/DRAIN) aborts the dump, flushes the buffer, discards the in-flight return, clears initDone, rstIndex=0 -> INIT the next cycle. initStart during INIT restarts from 0.
- Simultaneous initStart and dumpReq: initStart wins; dumpReq is dropped.
- rdGrant low for arbitrary stretches: no beat lost; rdAddr held stable while rdReq && !rdGrant.
- Async reset mid-dump: immediate return to INIT; outValid falls asynchronously.

Decomposition:
- Shared package (BasicTypes or a new RegisterFileTypes): MaintState enum {INIT, IDLE, DUMP, DRAIN}; PRegDataPath; PScalarRegNumPath for the index.
- Sub-module preg_dump_skid_buf: 2-entry valid/ready FIFO with flush, reused for the FP register file instance.
- Instantiate twice (INT and FP) with RSD_MARCH_FP_PIPE; initDone of both is ANDed upstream.

Test Plan:
- Reset release, ENTRY_NUM=64, WRITE_NUM=4 -> initWE=4'b1111 for 16 cycles, WA 0..63 each exactly once, initDone=1 on cycle 17, all written values 0x0 valid=1.
- ENTRY_NUM=10, WRITE_NUM=4 -> 3 beats; third beat initWE=4'b0011 (addresses 8,9); no write to address 0 from wrap.
- dumpReq after init, rdGrant=1, outReady=1 -> 64 beats, outIndex 0..63 in order, dumpBusy low 2 cycles after the last accepted read.
- rdGrant random 30%, outReady random 50% -> exactly 64 ordered beats; outData stable under backpressure; never more than 2 reads outstanding plus buffered.
- initStart asserted at dump beat 20 -> outValid=0 next cycle, no further beats, INIT sweep from 0, initDone=1 after 16 cycles.
- dumpReq during INIT, and dumpReq simultaneous with initStart -> no dump occurs; dumpBusy stays 0.
